// File: rtl/itof_pipe.sv
// itof_pipe: three-stage pipelined signed 32-bit integer to IEEE-754 single
// precision converter. Fractions are rounded half away from zero.
//
// Stages:
//   S1  sign / magnitude split
//   S2  leading-zero count and normalize
//   S3  round and pack
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   upstream presents operand a
//   in_ready   operand is accepted this cycle (low only while the output stalls)
//   a          two's-complement signed integer operand
//   out_valid  c holds a valid result
//   out_ready  downstream consumes c this cycle
//   c          IEEE-754 single result {sign, exponent[7:0], fraction[22:0]}
//
// All three stages advance together whenever the output is not stalled, so
// bubbles travel down the pipe instead of being squeezed out.
module itof_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c
);

    logic        stall;

    // Stage 1 registers
    logic        v1_q, v1_d;
    logic        s1_q, s1_d;
    logic [31:0] mag1_q, mag1_d;

    // Stage 2 registers. Only bits [31:7] of the normalized value are kept
    // because the rounder only looks at the 24-bit mantissa plus guard bit.
    logic        v2_q, v2_d;
    logic        s2_q, s2_d;
    logic        zero2_q, zero2_d;
    logic [4:0]  lz2_q, lz2_d;
    logic [24:0] norm2_q, norm2_d;

    // Stage 3 registers
    logic        v3_q, v3_d;
    logic [31:0] c3_q, c3_d;

    // Stage 2/3 combinational helpers
    logic [4:0]  lz;
    logic        lz_found;
    logic        carry;
    logic [22:0] frac_r;
    logic [7:0]  exp_r;

    assign stall     = v3_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v3_q;
    assign c         = c3_q;

    // S1: split the operand into sign and unsigned magnitude. The most
    // negative value negates to itself, which is the correct magnitude 2^31.
    always_comb begin
        v1_d   = v1_q;
        s1_d   = s1_q;
        mag1_d = mag1_q;
        if (!stall) begin
            v1_d   = in_valid;
            s1_d   = a[31];
            mag1_d = a[31] ? (~a + 32'd1) : a;
        end
    end

    // Priority search from the MSB for the first set bit.
    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!lz_found && mag1_q[i]) begin
                lz       = 5'(31 - i);
                lz_found = 1'b1;
            end
        end
    end

    // S2: normalize so the leading one lands in bit 31.
    always_comb begin
        v2_d    = v2_q;
        s2_d    = s2_q;
        zero2_d = zero2_q;
        lz2_d   = lz2_q;
        norm2_d = norm2_q;
        if (!stall) begin
            v2_d    = v1_q;
            s2_d    = s1_q;
            zero2_d = (mag1_q == 32'd0);
            lz2_d   = lz;
            norm2_d = 25'((mag1_q << lz) >> 7);
        end
    end

    // S3 rounding. norm2_q[24] is the hidden one, [23:1] the fraction and
    // [0] the guard bit. Adding the guard can only carry out of the mantissa
    // when every kept bit is one; the 23-bit fraction sum then wraps to zero,
    // which is exactly the fraction of the next power of two.
    always_comb begin
        carry  = &norm2_q;
        frac_r = norm2_q[23:1] + {22'd0, norm2_q[0]};
        exp_r  = 8'd158 - {3'd0, lz2_q} + {7'd0, carry};
    end

    // S3: pack the result; zero input gives +0.0.
    always_comb begin
        v3_d = v3_q;
        c3_d = c3_q;
        if (!stall) begin
            v3_d = v2_q;
            c3_d = zero2_q ? 32'd0 : {s2_q, exp_r, frac_r};
        end
    end

    // All stage registers. Reset also clears the data so c reads zero after
    // reset, and it overrides any operand presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            mag1_q  <= 32'd0;
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            zero2_q <= 1'b1;
            lz2_q   <= 5'd0;
            norm2_q <= 25'd0;
            v3_q    <= 1'b0;
            c3_q    <= 32'd0;
        end else begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            mag1_q  <= mag1_d;
            v2_q    <= v2_d;
            s2_q    <= s2_d;
            zero2_q <= zero2_d;
            lz2_q   <= lz2_d;
            norm2_q <= norm2_d;
            v3_q    <= v3_d;
            c3_q    <= c3_d;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: self-checking bench for itof_pipe.
// A behavioural int-to-float model (ties rounded away from zero) feeds a
// scoreboard queue at every accepted operand; a single negedge monitor
// checks every output transfer, handshake consistency, stall stability and
// latency, and keeps the comparison counts printed in the summary line.
module tb_itof_pipe;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a         = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        bit          lat_chk;
    } exp_t;

    exp_t        sb[$];
    int          total      = 0;
    int          bad        = 0;
    int          cyc        = 0;
    int          acc_count  = 0;
    int          out_count  = 0;
    int          mode       = 3;   // 0 ready high, 1 random, 2 scripted stall, 3 ready low
    bit          bp_started = 1'b0;
    int          bp_left    = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_c     = 32'd0;

    always #5 clk = ~clk;

    itof_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    // Reference conversion: find the exponent of the magnitude, keep 24
    // significant bits and round up when the dropped remainder is at least half.
    function automatic logic [31:0] ref_itof(input logic [31:0] val);
        longint m, sc, r, half;
        int     k, sh;
        logic   s;
        if (val == 32'd0) return 32'd0;
        s = val[31];
        m = longint'($signed(val));
        if (m < 0) m = -m;
        k = 0;
        while ((m >> (k + 1)) != 0) k++;
        if (k <= 23) begin
            sc = m << (23 - k);
        end else begin
            sh   = k - 23;
            sc   = m >> sh;
            r    = m - (sc << sh);
            half = longint'(1) << (sh - 1);
            if (r >= half) sc++;
            if (sc == (longint'(1) << 24)) begin
                sc = longint'(1) << 23;
                k++;
            end
        end
        return {s, 8'(k + 127), sc[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(0, 31);
            2: v = -($urandom >> $urandom_range(0, 31));
            default: begin
                case ($urandom_range(0, 6))
                    0: v = 32'h0000_0000;
                    1: v = 32'h0000_0001;
                    2: v = 32'hFFFF_FFFF;
                    3: v = 32'h8000_0000;
                    4: v = 32'h7FFF_FFFF;
                    5: v = 32'h0100_0001;
                    default: v = 32'h00FF_FFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout/unexpected expected normal progress (cycle %0d)", name, cyc);
    endtask

    // Present one operand and hold it until it is accepted. Called at posedge+1.
    task automatic applyStimulus(input logic [31:0] val);
        int n;
        bit took;
        n        = 0;
        took     = 1'b0;
        in_valid = 1'b1;
        a        = val;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 1000);
        if (!took) failNow("accept_timeout");
        in_valid = 1'b0;
    endtask

    task automatic drainPipe();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) failNow("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Downstream ready generator, updated a little after each rising edge.
    always @(posedge clk) begin
        #2;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (!bp_started && out_valid) begin
                    bp_started = 1'b1;
                    bp_left    = 5;
                end
                if (bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: records accepts into the scoreboard and checks every output
    // transfer, the ready/stall relation and stability of c while stalled.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            acc_count  = acc_count - sb.size();
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                checkOutput("stall_c", c, prev_c);
                checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", c, e.val);
                    if (e.lat_chk) checkOutput("latency", 32'(cyc - e.cyc), 32'd3);
                    out_count++;
                end
            end
            if (in_valid && in_ready) begin
                e.val     = ref_itof(a);
                e.cyc     = cyc;
                e.lat_chk = (mode == 0);
                sb.push_back(e);
                acc_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c;
        end
    end

    initial begin
        logic [31:0] dir [7];
        dir = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
                32'h0100_0001, 32'h7FFF_FFFF, 32'h00FF_FFFF};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_c", c, 32'd0);

        // Hand-computed values pin the reference model.
        checkOutput("model_one", ref_itof(32'h0000_0001), 32'h3F80_0000);
        checkOutput("model_minus_one", ref_itof(32'hFFFF_FFFF), 32'hBF80_0000);
        checkOutput("model_zero", ref_itof(32'h0000_0000), 32'h0000_0000);
        checkOutput("model_min_int", ref_itof(32'h8000_0000), 32'hCF00_0000);
        checkOutput("model_tie", ref_itof(32'h0100_0001), 32'h4B80_0001);
        checkOutput("model_carry", ref_itof(32'h7FFF_FFFF), 32'h4F00_0000);
        checkOutput("model_exact", ref_itof(32'h00FF_FFFF), 32'h4B7F_FFFF);

        // Directed values with ready held high (latency checked).
        @(posedge clk);
        #1 mode = 0;
        foreach (dir[i]) applyStimulus(dir[i]);
        drainPipe();

        // Eight back-to-back operands with a five-cycle output stall.
        bp_started = 1'b0;
        mode       = 2;
        repeat (8) applyStimulus(rand_op());
        drainPipe();

        // Random operands with random downstream backpressure.
        mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(rand_op());
        end
        drainPipe();

        // Three operands in flight, then a one-cycle reset.
        mode = 3;
        applyStimulus(32'h0000_0005);
        applyStimulus(32'hFFFF_FFF6);
        applyStimulus(32'h0001_0000);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_c", c, 32'd0);
        @(posedge clk);
        #1 mode = 0;
        applyStimulus(32'hFFFF_FF85);
        drainPipe();

        checkOutput("result_count", 32'(out_count), 32'(acc_count));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
